bcd_down_timer: RTL and testbench
=================================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of cascaded BCD digits (legal range 1..8).
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit, the reset: asynchronous and active-high.
REQ-004 The block SHALL have port data, input, 4*DIGITS bits, the BCD load value with the least-significant digit in bits [3:0].
REQ-005 The block SHALL have port loadn, input, 1 bit, an active-low synchronous load request.
REQ-006 The block SHALL have port enable, input, 1 bit, an active-high count enable.
REQ-007 The block SHALL have port count, output, 4*DIGITS bits, the registered BCD count value.
REQ-008 The block SHALL have port tc, output, 1 bit, a registered terminal-count pulse.
REQ-009 The block SHALL have port zero, output, 1 bit, which is high when count equals all zeros.
REQ-010 The block SHALL have port busy, output, 1 bit, which is high when the state is COUNT.

Function
REQ-011 The state machine SHALL have states IDLE, COUNT and DONE.
REQ-012 The reload register SHALL hold the last loaded value.
REQ-013 Load SHALL occur when loadn=0, independent of enable and of state.
REQ-014 On load, any data digit greater than 9 SHALL be replaced by 9 before it is stored.
REQ-015 On load, the sanitised value SHALL be written to both count and the reload register in the same edge.
REQ-016 On load, the next state SHALL be COUNT if the sanitised value is nonzero, else DONE; tc SHALL be 0.
REQ-017 Load SHALL have priority over decrement when loadn=0 and enable=1 are asserted together.
REQ-018 In COUNT with enable=1 and loadn=1, count SHALL decrement by 1 in BCD.
REQ-019 In a BCD decrement, a digit at 0 SHALL become 9 and borrow from the next digit; other digits SHALL decrement by 1.
REQ-020 A decrement that makes count all zeros SHALL set tc=1 in the same edge and move the state to DONE.
REQ-021 tc SHALL be high for exactly one clock after each terminal count, then return to 0.
REQ-022 When enable=0, count, the reload register and the state SHALL hold, and tc SHALL be 0.
REQ-023 In IDLE, count SHALL stay 0 regardless of enable; only a load SHALL leave IDLE.
REQ-024 In DONE without reload (see Configuration), count SHALL stay 0 and the state SHALL stay DONE until the next load.
REQ-025 count SHALL never hold a non-BCD digit.
REQ-026 count SHALL never wrap below zero.
REQ-027 zero and busy SHALL be decoded combinationally from registers, with no added latency.

Reset
REQ-028 While clr=1, count, the reload register and tc SHALL be 0, the state SHALL be IDLE, zero SHALL be 1 and busy SHALL be 0, with no clock required.
REQ-029 An assertion of clr in mid-count SHALL abort the count immediately with no tc pulse.
REQ-030 After clr is released, the first edge SHALL evaluate loadn and enable normally.

Configuration
REQ-031 The macro BCD_TIMER_AUTO_RELOAD_EN SHALL control auto-reload.
REQ-032 With BCD_TIMER_AUTO_RELOAD_EN defined: in DONE with enable=1 and loadn=1, count SHALL take the reload register value and the state SHALL become COUNT if that value is nonzero, else stay DONE; tc SHALL be 0 on the reload edge.
REQ-033 With BCD_TIMER_AUTO_RELOAD_EN defined, the resulting terminal-count period SHALL be N+1 enabled clocks for a load value N.
REQ-034 Without BCD_TIMER_AUTO_RELOAD_EN, DONE SHALL be one-shot per REQ-024, and the reload register MAY be removed by synthesis.

Verification (DIGITS=2 unless stated)
REQ-035 Stimulus: clr=1 mid-count at count=0x37 -> count=0x00, zero=1, busy=0, tc=0 at once, without a clock edge.
REQ-036 Stimulus: load 0x12, then enable=1 -> count sequence 0x11, 0x10, 0x09, ..., 0x01, 0x00; tc=1 only on the edge where count becomes 0x00; then count stays 0x00 with tc=0 (one-shot build).
REQ-037 Stimulus: load 0x3C -> count=0x39; load 0x00 -> state DONE, zero=1, tc never asserted.
REQ-038 Stimulus: loadn=0 with data 0x05 and enable=1 while count=0x20 -> count=0x05, with no decrement on that edge.
REQ-039 Stimulus: enable toggling 1,0,0,1 starting from count=0x02 -> count 0x01, 0x01, 0x01, 0x00; tc=1 only on the last edge.
REQ-040 Stimulus: with BCD_TIMER_AUTO_RELOAD_EN defined, load 0x03 and hold enable=1 -> count 3, 2, 1, 0, 3, 2, 1, 0, ...; tc pulses once every 4 clocks.

Source files
------------

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable cascaded-BCD down counter with a one-clock terminal-count pulse.
// Define BCD_TIMER_AUTO_RELOAD_EN to restart from the last loaded value on enabled clocks in DONE.
`default_nettype none

module bcd_down_timer #(
    parameter int DIGITS = 2
) (
    input  logic                clock,
    input  logic                clr,
    input  logic [4*DIGITS-1:0] data,
    input  logic                loadn,
    input  logic                enable,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                zero,
    output logic                busy
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   count_q;
    logic           tc_q;
    logic [W-1:0]   load_d;
    logic [W-1:0]   dec_d;

    // Each load digit is clamped to 9 so count can never hold a non-BCD digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_sanitise
        assign load_d[4*g +: 4] = (data[4*g +: 4] > 4'd9) ? 4'd9 : data[4*g +: 4];
    end

    always_comb begin
        logic borrow;
        dec_d  = count_q;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_d[4*i +: 4] = 4'd9;
                end else begin
                    dec_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    // The reload register only has a consumer in the auto-reload build.
    logic [W-1:0] reload_q;

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            reload_q <= '0;
        end else if (!loadn) begin
            reload_q <= load_d;
        end
    end
`endif

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else if (!loadn) begin
            count_q <= load_d;
            state_q <= (load_d != '0) ? COUNT : DONE;
            tc_q    <= 1'b0;
        end else if (!enable) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                COUNT: begin
                    if (count_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        count_q <= dec_d;
                        if (dec_d == '0) begin
                            tc_q    <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                    count_q <= reload_q;
                    state_q <= (reload_q != '0) ? COUNT : DONE;
`else
                    count_q <= '0;
                    state_q <= DONE;
`endif
                end
                default: begin
                    count_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign zero  = (count_q == '0);
    assign busy  = (state_q == COUNT);

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer (DIGITS=2): a decimal-integer model queues expectations per clock.
`default_nettype none

module tb_bcd_down_timer;

    logic       clock = 1'b0;
    logic       clr   = 1'b1;
    logic [7:0] data  = 8'h00;
    logic       loadn = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] count;
    logic       tc, zero, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] count;
        logic       tc;
        logic       zero;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    // Model state: decimal integers, 0=IDLE 1=COUNT 2=DONE
    int m_count  = 0;
    int m_reload = 0;
    int m_state  = 0;
    bit m_tc     = 0;

    bcd_down_timer #(.DIGITS(2)) dut (
        .clock (clock),
        .clr   (clr),
        .data  (data),
        .loadn (loadn),
        .enable(enable),
        .count (count),
        .tc    (tc),
        .zero  (zero),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd_to_int(input logic [7:0] v);
        int d0, d1;
        d0 = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        d1 = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        return d1 * 10 + d0;
    endfunction

    function automatic logic [7:0] int_to_bcd(input int n);
        logic [3:0] hi, lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    task automatic model_step(input logic ld_n, input logic en, input logic [7:0] d);
        int v;
        m_tc = 0;
        if (!ld_n) begin
            v        = bcd_to_int(d);
            m_count  = v;
            m_reload = v;
            m_state  = (v != 0) ? 1 : 2;
        end else if (en) begin
            if (m_state == 1) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_tc    = 1;
                    m_state = 2;
                end
            end else if (m_state == 2) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                m_count = m_reload;
                m_state = (m_reload != 0) ? 1 : 2;
`endif
            end
        end
    endtask

    task automatic cycle(input logic ld_n, input logic en, input logic [7:0] d, input string tag);
        exp_t e;
        @(negedge clock);
        loadn  = ld_n;
        enable = en;
        data   = d;
        model_step(ld_n, en, d);
        e.tag   = tag;
        e.count = int_to_bcd(m_count);
        e.tc    = m_tc;
        e.zero  = (m_count == 0);
        e.busy  = (m_state == 1);
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_count"}, 32'(count), 32'(e.count));
            check({e.tag, "_tc"},    32'(tc),    32'(e.tc));
            check({e.tag, "_zero"},  32'(zero),  32'(e.zero));
            check({e.tag, "_busy"},  32'(busy),  32'(e.busy));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset is visible before any clock edge.
        #3;
        check("rst_count", 32'(count), 32'h00);
        check("rst_zero",  32'(zero),  32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_tc",    32'(tc),    32'd0);
        @(negedge clock);
        clr = 1'b0;

        cycle(1, 1, 8'h00, "idle_en");
        cycle(1, 0, 8'h00, "idle_hold");

        cycle(0, 0, 8'h12, "ld12");
        for (int i = 0; i < 12; i++) cycle(1, 1, 8'h00, "dn12");
        cycle(1, 1, 8'h00, "after0_a");
        cycle(1, 1, 8'h00, "after0_b");
        cycle(1, 0, 8'h00, "after0_c");

        cycle(0, 1, 8'h3C, "ld3C");
        cycle(1, 0, 8'h00, "hold39");
        cycle(0, 0, 8'h00, "ld00");
        cycle(1, 1, 8'h00, "zero_en_a");
        cycle(1, 1, 8'h00, "zero_en_b");

        cycle(0, 0, 8'hFF, "ldFF");
        cycle(1, 1, 8'h00, "dn99");

        cycle(0, 0, 8'h21, "ld21");
        cycle(1, 1, 8'h00, "dn21");
        cycle(0, 1, 8'h05, "ld_prio05");
        cycle(1, 1, 8'h00, "dn05");

        cycle(0, 0, 8'h02, "ld02");
        cycle(1, 1, 8'h00, "tog1");
        cycle(1, 0, 8'h00, "tog0a");
        cycle(1, 0, 8'h00, "tog0b");
        cycle(1, 1, 8'h00, "tog1b");

`ifdef BCD_TIMER_AUTO_RELOAD_EN
        cycle(0, 1, 8'h03, "ar_ld03");
        for (int i = 0; i < 12; i++) cycle(1, 1, 8'h00, "ar_run");
`endif

        for (int i = 0; i < 40; i++) begin
            logic [7:0] rd;
            rd = 8'($urandom_range(0, 255));
            cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), rd, "rand");
        end

        // Asynchronous abort mid-count.
        cycle(0, 0, 8'h38, "ld38");
        cycle(1, 1, 8'h00, "dn37");
        #2;
        clr = 1'b1;
        #1;
        check("clr_count", 32'(count), 32'h00);
        check("clr_zero",  32'(zero),  32'd1);
        check("clr_busy",  32'(busy),  32'd0);
        check("clr_tc",    32'(tc),    32'd0);
        m_count  = 0;
        m_reload = 0;
        m_state  = 0;
        m_tc     = 0;
        @(negedge clock);
        clr = 1'b0;
        cycle(0, 1, 8'h15, "post_clr_ld15");
        cycle(1, 1, 8'h00, "post_clr_dn");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
